// File: rtl/instr_decode_stage.sv
// ----------------------------------------------------------------------------
// instr_decode_stage
//
// Purpose:
//   Decode stage of a small RV32-subset pipeline. An instruction word and its
//   PC are accepted through a valid/ready handshake, decoded into an ALU
//   operation code, immediate, shift amount and register addresses, and
//   presented to the execute stage one cycle later through a second handshake.
//   Unsupported encodings are flagged as illegal and counted as they are
//   consumed.
//
// Configuration macro:
//   DECODE_SKID_EN - when defined, a 2-entry skid buffer with a registered
//                    in_ready is used. When undefined (default), a single
//                    output register with in_ready = !out_valid || out_ready.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   flush        in   drop all held instructions, accept nothing this cycle
//   in_valid     in   fetch side: instruction offered
//   in_ready     out  fetch side: stage can take an instruction
//   instr        in   32-bit instruction word
//   pc           in   address of instr
//   out_valid    out  execute side: decoded result present
//   out_ready    in   execute side: result consumed this cycle
//   alu_cntrl    out  6-bit ALU operation (6'b111111 = illegal)
//   imm_val      out  32-bit immediate operand
//   shift_amount out  instr[23:20]
//   rs1_addr     out  instr[19:15]
//   rs2_addr     out  instr[24:20]
//   rd_addr      out  instr[11:7]
//   reg_we       out  destination register write enable
//   pc_out       out  PC of the presented instruction
//   illegal      out  presented instruction is illegal
//   illegal_cnt  out  saturating count of consumed illegal instructions
// ----------------------------------------------------------------------------
module instr_decode_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       alu_cntrl,
    output logic [31:0]      imm_val,
    output logic [3:0]       shift_amount,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic             reg_we,
    output logic [31:0]      pc_out,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [5:0] ALU_ILL  = 6'b111111;

    // Entry layout: {illegal, reg_we, alu, imm, shamt, rs1, rs2, rd, pc}
    localparam int ENT_W = 1 + 1 + 6 + 32 + 4 + 5 + 5 + 5 + 32;
    localparam logic [ENT_W-1:0] RESET_ENT = {2'b00, ALU_ILL, {(ENT_W-8){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [6:0]       w_op;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic [5:0]       w_alu;
    logic [31:0]      w_imm;
    logic             w_ill;
    logic             w_we;
    logic [ENT_W-1:0] w_dec_ent;
    logic [ENT_W-1:0] r_ent0;
    logic             w_push;
    logic [CNT_W-1:0] r_cnt;

    assign w_op = instr[6:0];
    assign w_f3 = instr[14:12];
    assign w_f7 = instr[31:25];

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = ALU_ILL;
        w_imm = 32'h0;
        case (w_op)
            OP_R: begin
                case ({w_f7, w_f3})
                    10'b0000000_000: w_alu = 6'b000000;
                    10'b0100000_000: w_alu = 6'b000001;
                    10'b0000000_001: w_alu = 6'b000010;
                    10'b0000000_010: w_alu = 6'b000011;
                    10'b0000000_011: w_alu = 6'b000100;
                    10'b0000000_100: w_alu = 6'b000101;
                    10'b0000000_101: w_alu = 6'b000110;
                    10'b0100000_101: w_alu = 6'b000111;
                    10'b0000000_110: w_alu = 6'b001000;
                    10'b0000000_111: w_alu = 6'b001001;
                    default:         w_alu = ALU_ILL;
                endcase
            end
            OP_I: begin
                w_imm = {{20{instr[31]}}, instr[31:20]};
                case (w_f3)
                    3'b000: w_alu = 6'b001010;
                    3'b001: w_alu = (w_f7 == 7'b0) ? 6'b001011 : ALU_ILL;
                    3'b010: w_alu = 6'b001100;
                    3'b011: w_alu = 6'b001101;
                    3'b100: w_alu = 6'b001110;
                    // SRAI (funct7 0100000) is deliberately unsupported
                    3'b101: w_alu = (w_f7 == 7'b0) ? 6'b001111 : ALU_ILL;
                    3'b110: w_alu = 6'b010000;
                    default: w_alu = 6'b010001;
                endcase
            end
            OP_LUI: begin
                // Upper immediate left unshifted; the ALU applies the << 12
                w_imm = {12'b0, instr[31:12]};
                w_alu = 6'b010010;
            end
            OP_STORE: begin
                w_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                case (w_f3)
                    3'b000:  w_alu = 6'b010111;
                    3'b001:  w_alu = 6'b011000;
                    3'b010:  w_alu = 6'b011001;
                    default: w_alu = ALU_ILL;
                endcase
            end
            OP_BR: begin
                w_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                case (w_f3)
                    3'b000:  w_alu = 6'b011010;
                    3'b001:  w_alu = 6'b011011;
                    3'b100:  w_alu = 6'b011100;
                    3'b101:  w_alu = 6'b011101;
                    default: w_alu = ALU_ILL;
                endcase
            end
            default: w_alu = ALU_ILL;
        endcase
        w_ill = (w_alu == ALU_ILL);
        if (w_ill) begin
            w_imm = 32'h0;
        end
        w_we = !w_ill && ((w_op == OP_R) || (w_op == OP_I) || (w_op == OP_LUI));
    end

    assign w_dec_ent = {w_ill, w_we, w_alu, w_imm, instr[23:20], instr[19:15],
                        instr[24:20], instr[11:7], pc};

    assign w_push = in_valid && in_ready;

`ifdef DECODE_SKID_EN
    // ------------------------------------------------------------------
    // Two-entry skid buffer; r_ent0 is always the head. in_ready comes from
    // a flop so there is no path from out_ready to in_ready.
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] r_ent1;
    logic [1:0]       r_count;
    logic             r_ready;
    logic             w_pop;

    assign w_pop     = (r_count != 2'd0) && out_ready;
    assign in_ready  = r_ready && rst_n && !flush;
    assign out_valid = (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_ready <= 1'b1;
            r_ent0  <= RESET_ENT;
            r_ent1  <= RESET_ENT;
        end else if (flush) begin
            r_count <= 2'd0;
            r_ready <= 1'b1;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_ent0 <= w_dec_ent;
                    end else begin
                        r_ent1 <= w_dec_ent;
                    end
                    r_count <= r_count + 2'd1;
                    r_ready <= (r_count == 2'd0);
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                    r_ready <= 1'b1;
                end
                // Push and pop together only happens with one entry held
                2'b11: r_ent0 <= w_dec_ent;
                default: ;
            endcase
        end
    end
`else
    // ------------------------------------------------------------------
    // Single output register; ready whenever the slot is empty or draining.
    // ------------------------------------------------------------------
    logic r_valid;

    assign in_ready  = rst_n && !flush && (!r_valid || out_ready);
    assign out_valid = r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ent0  <= RESET_ENT;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_push) begin
            r_valid <= 1'b1;
            r_ent0  <= w_dec_ent;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

    assign {illegal, reg_we, alu_cntrl, imm_val, shift_amount, rs1_addr, rs2_addr, rd_addr,
            pc_out} = r_ent0;

    // Flushed results are never consumed, so they do not count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (out_valid && out_ready && !flush && illegal && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_instr_decode_stage
//
// Directed and randomized stimulus for instr_decode_stage. Expected outputs
// come from an instruction-level reference: each accepted word is decoded
// from the ISA tables into an expected record and queued; the queue head is
// what the execute side must see. Works with or without DECODE_SKID_EN.
// ----------------------------------------------------------------------------
module tb_instr_decode_stage;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [5:0]  alu;
        logic [31:0] imm;
        logic [3:0]  sh;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       alu_cntrl;
    logic [31:0]      imm_val;
    logic [3:0]       shift_amount;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic             reg_we;
    logic [31:0]      pc_out;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int   total;
    int   bad;
    int   cnt_model;
    exp_t q[$];

    instr_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .pc           (pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_cntrl    (alu_cntrl),
        .imm_val      (imm_val),
        .shift_amount (shift_amount),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_addr      (rd_addr),
        .reg_we       (reg_we),
        .pc_out       (pc_out),
        .illegal      (illegal),
        .illegal_cnt  (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ISA-level reference decode
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
        exp_t e;
        int   op   = int'(w[6:0]);
        int   f3   = int'(w[14:12]);
        int   f7   = int'(w[31:25]);
        int   code = 63;
        int   imm  = 0;
        bit   wr   = 1'b0;
        int   rt0[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        case (op)
            'h33: begin
                if (f7 == 0) code = rt0[f3];
                else if (f7 == 'h20 && f3 == 0) code = 1;
                else if (f7 == 'h20 && f3 == 5) code = 7;
                wr = 1'b1;
            end
            'h13: begin
                if ((f3 != 1 && f3 != 5) || f7 == 0) code = 10 + f3;
                imm = int'(w[31:20]);
                if (imm >= 2048) imm = imm - 4096;
                wr = 1'b1;
            end
            'h37: begin
                code = 18;
                imm  = int'(w[31:12]);
                wr   = 1'b1;
            end
            'h23: begin
                if (f3 <= 2) code = 23 + f3;
                imm = int'(w[31:25]) * 32 + int'(w[11:7]);
                if (imm >= 2048) imm = imm - 4096;
            end
            'h63: begin
                if (f3 == 0) code = 26;
                else if (f3 == 1) code = 27;
                else if (f3 == 4) code = 28;
                else if (f3 == 5) code = 29;
                imm = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                    + int'(w[11:8]) * 2;
                if (w[31]) imm = imm - 8192;
            end
            default: code = 63;
        endcase
        e.ill = (code == 63);
        e.alu = 6'(code);
        e.imm = e.ill ? 32'h0 : imm;
        e.we  = wr && !e.ill;
        e.sh  = w[23:20];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        e.pc  = p;
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 6))
            0, 1: w[6:0] = 7'b0110011;
            2:    w[6:0] = 7'b0010011;
            3:    w[6:0] = 7'b0110111;
            4:    w[6:0] = 7'b0100011;
            5:    w[6:0] = 7'b1100011;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] legal_add();
        logic [31:0] w = $urandom;
        w[31:25] = 7'h00;
        w[6:0]   = 7'b0110011;
        return w;
    endfunction

    // One clock: check at the falling edge, advance the model, return after
    // the rising edge. acc reports whether the offered word was taken.
    task automatic step(output bit acc);
        bit   exp_ready;
        exp_t h;
        @(negedge clk);
        if (!rst_n || flush) exp_ready = 1'b0;
`ifdef DECODE_SKID_EN
        else exp_ready = (q.size() < 2);
`else
        else exp_ready = (q.size() == 0) || out_ready;
`endif
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, q.size() != 0);
        chk("illegal_cnt", illegal_cnt, cnt_model);
        if (q.size() != 0) begin
            h = q[0];
            chk("alu_cntrl", alu_cntrl, h.alu);
            chk("imm_val", imm_val, h.imm);
            chk("shift_amount", shift_amount, h.sh);
            chk("rs1_addr", rs1_addr, h.rs1);
            chk("rs2_addr", rs2_addr, h.rs2);
            chk("rd_addr", rd_addr, h.rd);
            chk("reg_we", reg_we, h.we);
            chk("pc_out", pc_out, h.pc);
            chk("illegal", illegal, h.ill);
        end
        acc = in_valid && exp_ready;
        if (!rst_n) begin
            q.delete();
            cnt_model = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_ready) begin
                if (q[0].ill && cnt_model < CNT_MAX) cnt_model++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(model(instr, pc));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int n_acc;
        total     = 0;
        bad       = 0;
        cnt_model = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h40208033;
        pc        = 32'h0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset state with input offered
        step(acc);
        step(acc);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_alu", alu_cntrl, 6'b111111);
        chk("rst_imm", imm_val, 0);
        chk("rst_shamt", shift_amount, 0);
        chk("rst_rs1", rs1_addr, 0);
        chk("rst_rs2", rs2_addr, 0);
        chk("rst_rd", rd_addr, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_cnt", illegal_cnt, 0);

        // SUB x0,x1,x2
        rst_n = 1'b1;
        pc    = 32'h100;
        step(acc);
        in_valid = 1'b0;
        chk("sub_valid", out_valid, 1);
        chk("sub_alu", alu_cntrl, 6'b000001);
        chk("sub_rs1", rs1_addr, 1);
        chk("sub_rs2", rs2_addr, 2);
        chk("sub_rd", rd_addr, 0);
        chk("sub_we", reg_we, 1);
        chk("sub_pc", pc_out, 32'h100);
        step(acc);

        // ADDI, LUI, BEQ back to back
        in_valid = 1'b1;
        instr    = 32'hFFF00093;
        pc       = 32'h104;
        step(acc);
        chk("addi_alu", alu_cntrl, 6'b001010);
        chk("addi_imm", imm_val, 32'hFFFFFFFF);
        instr = 32'h123450B7;
        pc    = 32'h108;
        step(acc);
        chk("lui_alu", alu_cntrl, 6'b010010);
        chk("lui_imm", imm_val, 32'h00012345);
        instr = 32'hFE000EE3;
        pc    = 32'h10C;
        step(acc);
        chk("beq_alu", alu_cntrl, 6'b011010);
        chk("beq_imm", imm_val, 32'hFFFFFFFC);
        chk("beq_we", reg_we, 0);
        in_valid = 1'b0;
        step(acc);

        // Back-pressure for 5 cycles with input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = legal_add();
        n_acc     = 0;
        repeat (5) begin
            step(acc);
            if (acc) begin
                n_acc++;
                instr = legal_add();
                pc    = pc + 32'd4;
            end
        end
`ifdef DECODE_SKID_EN
        chk("stall_accepts", n_acc, 2);
`else
        chk("stall_accepts", n_acc, 1);
`endif
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (3) step(acc);

        // Flush while full of illegal words, consumer ready on the flush cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h0;
        repeat (3) step(acc);
        flush     = 1'b1;
        out_ready = 1'b1;
        step(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_cnt", illegal_cnt, 0);
        step(acc);

        // Counter saturation: 300 consumed illegal words
        in_valid = 1'b1;
        instr    = 32'h0;
        repeat (300) step(acc);
        in_valid = 1'b0;
        repeat (3) step(acc);
        chk("sat_cnt", illegal_cnt, 255);

        // Flush while full with the counter saturated
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = legal_add();
        repeat (2) step(acc);
        flush = 1'b1;
        step(acc);
        flush = 1'b0;
        chk("flush2_valid", out_valid, 0);
        chk("flush2_cnt", illegal_cnt, 255);

        // Reset in the middle of operation
        repeat (2) step(acc);
        rst_n = 1'b0;
        step(acc);
        rst_n = 1'b1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_cnt", illegal_cnt, 0);

        // Randomized traffic
        instr = rnd_instr();
        repeat (500) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step(acc);
            if (acc || !in_valid) begin
                instr = rnd_instr();
                pc    = $urandom;
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step(acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port flush  in  1  discard all held instructions.
REQ-005 SHALL have ports in_valid  in  1 / in_ready  out  1  fetch-side handshake.
REQ-006 SHALL have ports instr  in  32 / pc  in  32  instruction word and its address.
REQ-007 SHALL have ports out_valid  out  1 / out_ready  in  1  execute-side handshake.
REQ-008 SHALL have port alu_cntrl  out  6  ALU operation code.
REQ-009 SHALL have ports imm_val  out  32 / shift_amount  out  4  ALU immediate operands.
REQ-010 SHALL have ports rs1_addr, rs2_addr, rd_addr  out  5 each / reg_we  out  1 / pc_out  out  32.
REQ-011 SHALL have ports illegal  out  1 / illegal_cnt  out  CNT_W  illegal flag and count.

Function
REQ-012 SHALL accept an instruction on a cycle where in_valid and in_ready are both high.
REQ-013 SHALL present the decoded result with out_valid high on the cycle after acceptance (1-cycle latency).
REQ-014 SHALL hold every output stable while out_valid is high and out_ready is low.
REQ-015 SHALL map R-type (opcode 0110011) funct3/funct7 to ADD 000000, SUB 000001, SLL 000010, SLT 000011, SLTU 000100, XOR 000101, SRL 000110, SRA 000111, OR 001000, AND 001001.
REQ-016 SHALL map I-type ALU ops (opcode 0010011) to ADDI 001010, SLLI 001011, SLTI 001100, SLTIU 001101, XORI 001110, SRLI 001111, ORI 010000, ANDI 010001.
REQ-017 SHALL map LUI 010010, SB 010111, SH 011000, SW 011001, BEQ 011010, BNE 011011, BLT 011100, BGE 011101.
REQ-018 SHALL sign-extend instr[31:20] to imm_val for I-type and instr[31:25,11:7] for stores; for branches it SHALL sign-extend the B-immediate with bit 0 = 0.
REQ-019 SHALL output imm_val = {12'b0, instr[31:12]} for LUI (the ALU applies the 12-bit shift).
REQ-020 SHALL set shift_amount = instr[23:20] for every instruction.
REQ-021 SHALL set reg_we high for R-type, I-type ALU and LUI, and low for stores, branches and illegal instructions.
REQ-022 SHALL treat any other opcode/funct combination (including SRAI) as illegal: alu_cntrl 111111, reg_we 0, illegal 1.
REQ-023 SHALL increment illegal_cnt by 1 when an illegal result is consumed (out_valid and out_ready), saturating at all-ones.
REQ-024 SHALL, on flush, clear all held entries (out_valid 0 next cycle) and not accept input that cycle; illegal_cnt SHALL be unchanged.
REQ-025 SHALL accept input and advance output in the same cycle when the stage is full and out_ready is high.

Reset
REQ-026 SHALL, while rst_n is low at a clock edge, set out_valid 0, illegal_cnt 0, alu_cntrl 111111, and all other outputs 0.
REQ-027 SHALL drop any in-flight instruction when reset is asserted mid-operation; in_ready SHALL be 0 while rst_n is low.

Configuration
REQ-028 SHALL, with DECODE_SKID_EN defined, use a 2-entry skid buffer: in_ready is registered and high whenever fewer than 2 entries are held, giving full throughput without a combinational ready path.
REQ-029 SHALL, without DECODE_SKID_EN, use a single output register with in_ready = !out_valid || out_ready (combinational).

Verification
REQ-030 SHALL cover: instr 0x40208033 (SUB x0,x1,x2) accepted -> next cycle alu_cntrl 000001, rs1 1, rs2 2, rd 0, reg_we 1.
REQ-031 SHALL cover: instr 0xFFF00093 (ADDI x1,x0,-1) -> alu_cntrl 001010, imm_val 0xFFFFFFFF.
REQ-032 SHALL cover: instr 0x123450B7 (LUI) -> alu_cntrl 010010, imm_val 0x00012345; then 0xFE000EE3 (BEQ x0,x0,-4) -> alu_cntrl 011010, imm_val 0xFFFFFFFC, reg_we 0.
REQ-033 SHALL cover: out_ready low for 5 cycles with in_valid high -> outputs stable, no loss; with DECODE_SKID_EN, exactly 2 instructions accepted before in_ready drops.
REQ-034 SHALL cover: 300 consumed 0x00000000 instructions with CNT_W 8 -> illegal_cnt saturates at 255; flush while full -> out_valid 0 next cycle, count unchanged.
